alu_display: RTL and testbench

ALU_DISPLAY -- requirements
Module: alu_display

---
 rtl/alu_pkg.sv | 47 ++++
 rtl/bin2bcd.sv | 55 +++++
 rtl/alu_display.sv | 134 +++++++++++++
 tb/tb_alu_display.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result display: FSM encoding, BCD geometry
// and the active-low seven-segment patterns ({g,f,e,d,c,b,a}).
package alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_COMMIT  = 2'd2
  } state_t;

  localparam int BIN_W      = 7;
  localparam int NIBBLE_W   = 4;
  localparam int BCD_DIGITS = 3;
  localparam int BCD_W      = NIBBLE_W * BCD_DIGITS;
  localparam int SHIFTS     = BIN_W;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_digit(input logic [NIBBLE_W-1:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd.sv
// Sequential double-dabble: one add-3/shift step per clock, BIN_W steps per
// conversion. done flags the cycle in which the final step is taken.
module bin2bcd
  import alu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [BIN_W-1:0]    bin,
  output logic [NIBBLE_W-1:0] hundreds,
  output logic [NIBBLE_W-1:0] tens,
  output logic [NIBBLE_W-1:0] units,
  output logic                done
);

  logic [BIN_W-1:0] bin_sr;
  logic [BCD_W-1:0] bcd_sr;
  logic [2:0]       cnt;
  logic             running;

  function automatic logic [BCD_W+BIN_W-1:0] dd_step(input logic [BCD_W-1:0] bcd,
                                                     input logic [BIN_W-1:0] b);
    logic [BCD_W-1:0] adj;
    adj = bcd;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (adj[i*NIBBLE_W +: NIBBLE_W] >= 4'd5)
        adj[i*NIBBLE_W +: NIBBLE_W] = adj[i*NIBBLE_W +: NIBBLE_W] + 4'd3;
    end
    return {adj, b} << 1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_sr  <= '0;
      bcd_sr  <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      bin_sr  <= bin;
      bcd_sr  <= '0;
      cnt     <= '0;
      running <= 1'b1;
    end else if (running) begin
      {bcd_sr, bin_sr} <= dd_step(bcd_sr, bin_sr);
      cnt              <= cnt + 3'd1;
      if (done) running <= 1'b0;
    end
  end

  assign done     = running && (cnt == 3'(SHIFTS - 1));
  assign hundreds = bcd_sr[2*NIBBLE_W +: NIBBLE_W];
  assign tens     = bcd_sr[NIBBLE_W +: NIBBLE_W];
  assign units    = bcd_sr[0 +: NIBBLE_W];

endmodule

// File: rtl/alu_display.sv
// Captures an ALU result and flags, converts to BCD, and multiplexes the
// result onto a 4-digit active-low seven-segment display.
module alu_display
  import alu_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BIN_W-1:0] result,
  input  logic             carry,
  input  logic             overflow,
  input  logic             zero,
  input  logic             load,
  output logic [6:0]       seg,
  output logic [3:0]       an,
  output logic             busy,
  output logic             zero_led
);

  localparam int              CNT_W   = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  state_t              state, state_nxt;
  logic                start, conv_done;
  logic                cap_carry, cap_ovf, cap_zero;
  logic [NIBBLE_W-1:0] bcd_h, bcd_t, bcd_u;
  logic [NIBBLE_W-1:0] disp_h, disp_t, disp_u;
  logic                disp_carry, disp_ovf;
  logic [CNT_W-1:0]    scan_cnt;
  logic [1:0]          digit_idx;
  logic [6:0]          seg_nxt;

  bin2bcd u_bin2bcd (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bin      (result),
    .hundreds (bcd_h),
    .tens     (bcd_t),
    .units    (bcd_u),
    .done     (conv_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Loads are only honoured from IDLE; CONVERT and COMMIT ignore them.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (load) begin
          start     = 1'b1;
          state_nxt = ST_CONVERT;
        end
      end
      ST_CONVERT: if (conv_done) state_nxt = ST_COMMIT;
      ST_COMMIT:  state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_carry <= 1'b0;
      cap_ovf   <= 1'b0;
      cap_zero  <= 1'b0;
    end else if (start) begin
      cap_carry <= carry;
      cap_ovf   <= overflow;
      cap_zero  <= zero;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_h     <= '0;
      disp_t     <= '0;
      disp_u     <= '0;
      disp_carry <= 1'b0;
      disp_ovf   <= 1'b0;
      zero_led   <= 1'b0;
    end else if (state == ST_COMMIT) begin
      disp_h     <= bcd_h;
      disp_t     <= bcd_t;
      disp_u     <= bcd_u;
      disp_carry <= cap_carry;
      disp_ovf   <= cap_ovf;
      zero_led   <= cap_zero;
    end
  end

  // Free-running scan, independent of the conversion FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else if (scan_cnt == CNT_MAX) begin
      scan_cnt  <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      scan_cnt  <= scan_cnt + 1'b1;
    end
  end

  always_comb begin
    seg_nxt = SEG_BLANK;
    case (digit_idx)
      2'd0: seg_nxt = seg_digit(disp_u);
      2'd1: seg_nxt = (disp_h == '0 && disp_t == '0) ? SEG_BLANK : seg_digit(disp_t);
      2'd2: seg_nxt = (disp_h == '0) ? SEG_BLANK : seg_digit(disp_h);
      2'd3: seg_nxt = disp_ovf ? SEG_E : (disp_carry ? SEG_C : SEG_BLANK);
      default: seg_nxt = SEG_BLANK;
    endcase
  end

  // an and seg share one register stage so they always change together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
    end else begin
      an  <= ~(4'b0001 << digit_idx);
      seg <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_alu_display.sv
// Bench for alu_display: directed scenarios plus random loads, checked each
// cycle against a behavioural model of the display contents and scan.
module tb_alu_display;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] result;
  logic       carry, overflow, zero, load;
  logic [6:0] seg;
  logic [3:0] an;
  logic       busy, zero_led;

  int n_vec = 0;
  int n_err = 0;

  // Model state
  int busy_left;
  int cap_v, d_v;
  bit cap_c, cap_o, cap_z, d_c, d_o, d_z;
  int k;

  logic [6:0] enc [10];
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] ENC_E = 7'b0000110;
  localparam logic [6:0] ENC_C = 7'b1000110;

  alu_display #(.REFRESH_DIV(DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .result   (result),
    .carry    (carry),
    .overflow (overflow),
    .zero     (zero),
    .load     (load),
    .seg      (seg),
    .an       (an),
    .busy     (busy),
    .zero_led (zero_led)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] exp_digit(input int idx);
    int h, t, u;
    h = d_v / 100;
    t = (d_v / 10) % 10;
    u = d_v % 10;
    case (idx)
      0:       return enc[u];
      1:       return (h == 0 && t == 0) ? BLANK : enc[t];
      2:       return (h == 0) ? BLANK : enc[h];
      default: return d_o ? ENC_E : (d_c ? ENC_C : BLANK);
    endcase
  endfunction

  function automatic void model_reset();
    busy_left = 0;
    cap_v = 0; cap_c = 0; cap_o = 0; cap_z = 0;
    d_v = 0;   d_c = 0;   d_o = 0;   d_z = 0;
    k = 0;
  endfunction

  task automatic cycle(input logic ld, input logic [6:0] r, input logic c, input logic o,
                       input logic z);
    int idx;
    logic [3:0] ea;
    logic [6:0] es;
    load = ld; result = r; carry = c; overflow = o; zero = z;
    idx = (k / DIV) % 4;
    ea = ~(4'b0001 << idx);
    es = exp_digit(idx);
    @(posedge clk);
    if (busy_left == 0 && ld) begin
      cap_v = int'(r); cap_c = c; cap_o = o; cap_z = z;
      busy_left = 8;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) begin
        d_v = cap_v; d_c = cap_c; d_o = cap_o; d_z = cap_z;
      end
    end
    k++;
    #1;
    check("an", 32'(an), 32'(ea));
    check("seg", 32'(seg), 32'(es));
    check("busy", 32'(busy), 32'(busy_left != 0));
    check("zero_led", 32'(zero_led), 32'(d_z));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    load = 1'b0;
    rst  = 1'b1;
    #1;
    model_reset();
    check("rst_an", 32'(an), 32'hf);
    check("rst_seg", 32'(seg), 32'h7f);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_zero_led", 32'(zero_led), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_an", 32'(an), 32'hf);
    check("rst_hold_busy", 32'(busy), 32'h0);
    rst = 1'b0;
  endtask

  initial begin
    enc = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    rst = 1'b0; load = 1'b0; result = '0; carry = 1'b0; overflow = 1'b0; zero = 1'b0;
    #2;
    do_reset();

    // Idle scan after reset
    idle(20);

    // 127, no flags
    cycle(1'b1, 7'd127, 1'b0, 1'b0, 1'b0);
    idle(30);

    // zero result with zero flag
    cycle(1'b1, 7'd0, 1'b0, 1'b0, 1'b1);
    idle(30);

    // overflow wins over carry
    cycle(1'b1, 7'd16, 1'b1, 1'b1, 1'b0);
    idle(30);

    // loads during CONVERT and during COMMIT are dropped
    cycle(1'b1, 7'd5, 1'b0, 1'b0, 1'b0);
    idle(2);
    cycle(1'b1, 7'd9, 1'b1, 1'b0, 1'b1);
    idle(4);
    cycle(1'b1, 7'd9, 1'b0, 1'b1, 1'b1);
    idle(20);

    // reset mid-conversion aborts with no commit
    cycle(1'b1, 7'd99, 1'b1, 1'b0, 1'b1);
    idle(3);
    do_reset();
    idle(24);

    // randomized loads
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 5) == 0), 7'($urandom_range(0, 127)),
            1'($urandom), 1'($urandom), 1'($urandom));
    end
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
